// File: rtl/wshb_rr_arbiter.sv
// rtl/wshb_rr_arbiter.sv - two-master round-robin Wishbone arbiter with bounded-hold preemption
// Grants the shared slave to one master at a time, always passing through one IDLE cycle on a switch.
module wshb_rr_arbiter #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 32,
  parameter int MAX_HOLD   = 64,
  parameter int CNT_W      = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,

  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_W-1:0]       m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,

  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_W-1:0]       m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,

  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,

  output logic [1:0]              gnt
);

  localparam bit PREEMPT_EN = (MAX_HOLD > 0);
  // Counter ceiling: one below MAX_HOLD, so the final permitted transfer is the preempting one.
  localparam logic [CNT_W-1:0] HOLD_LAST = PREEMPT_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic term;
  logic hold_done;
  logic [CNT_W-1:0] cnt_inc;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign term      = s_stb & (s_ack | s_err | s_rty);
  assign hold_done = PREEMPT_EN && (cnt_q == HOLD_LAST) && term;
  assign cnt_inc   = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = GNT0;
          cnt_d   = '0;
        end else if (m1_cyc) begin
          state_d = GNT1;
          cnt_d   = '0;
        end
      end
      GNT0: begin
        if (!m0_cyc || (hold_done && m1_cyc)) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (term) begin
          cnt_d = cnt_inc;
        end
      end
      GNT1: begin
        if (!m1_cyc || (hold_done && m0_cyc)) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (term) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data is broadcast; only the terminations are steered to the granted master.
  always_comb begin
    gnt       = 2'b00;
    s_cyc     = 1'b0;
    s_stb     = 1'b0;
    s_we      = 1'b0;
    s_adr     = '0;
    s_dat_ms  = '0;
    s_sel     = '0;
    s_cti     = '0;
    s_bte     = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rty    = 1'b0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rty    = 1'b0;
    m0_dat_sm = s_dat_sm;
    m1_dat_sm = s_dat_sm;
    case (state_q)
      GNT0: begin
        gnt      = 2'b01;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = m0_stb & s_ack;
        m0_err   = m0_stb & s_err;
        m0_rty   = m0_stb & s_rty;
      end
      GNT1: begin
        gnt      = 2'b10;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = m1_stb & s_ack;
        m1_err   = m1_stb & s_err;
        m1_rty   = m1_stb & s_rty;
      end
      default: begin
        gnt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_rr_arbiter.sv
// tb/tb_wshb_rr_arbiter.sv - directed vector bench for wshb_rr_arbiter
// Runs with MAX_HOLD=4 so preemption boundaries are reached quickly.
module tb_wshb_rr_arbiter;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty;
  logic [31:0] m0_adr, m0_dat_ms, m0_dat_sm;
  logic [3:0]  m0_sel;
  logic [2:0]  m0_cti;
  logic [1:0]  m0_bte;
  logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty;
  logic [31:0] m1_adr, m1_dat_ms, m1_dat_sm;
  logic [3:0]  m1_sel;
  logic [2:0]  m1_cti;
  logic [1:0]  m1_bte;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [31:0] s_adr, s_dat_ms, s_dat_sm;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic [1:0]  gnt;

  int n_cmp;
  int n_bad;

  wshb_rr_arbiter #(
    .DATA_BYTES(4),
    .ADDR_W    (32),
    .MAX_HOLD  (4),
    .CNT_W     (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .m0_cyc   (m0_cyc),
    .m0_stb   (m0_stb),
    .m0_we    (m0_we),
    .m0_adr   (m0_adr),
    .m0_dat_ms(m0_dat_ms),
    .m0_sel   (m0_sel),
    .m0_cti   (m0_cti),
    .m0_bte   (m0_bte),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m0_rty   (m0_rty),
    .m0_dat_sm(m0_dat_sm),
    .m1_cyc   (m1_cyc),
    .m1_stb   (m1_stb),
    .m1_we    (m1_we),
    .m1_adr   (m1_adr),
    .m1_dat_ms(m1_dat_ms),
    .m1_sel   (m1_sel),
    .m1_cti   (m1_cti),
    .m1_bte   (m1_bte),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .m1_rty   (m1_rty),
    .m1_dat_sm(m1_dat_sm),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_ms (s_dat_ms),
    .s_sel    (s_sel),
    .s_cti    (s_cti),
    .s_bte    (s_bte),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .s_rty    (s_rty),
    .s_dat_sm (s_dat_sm),
    .gnt      (gnt)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  typedef struct {
    logic        c0, s0, c1, s1, ack, err;
    logic [1:0]  x_gnt;
    logic        x_cyc, x_stb, x_we, x_a0, x_a1, x_e0, x_e1;
    logic [15:0] x_adr;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic apply(input logic c0, input logic s0, input logic c1, input logic s1,
                       input logic ack, input logic err);
    m0_cyc = c0;
    m0_stb = s0;
    m1_cyc = c1;
    m1_stb = s1;
    s_ack  = ack;
    s_err  = err;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
  endtask

  function automatic logic [63:0] pack_out();
    return {37'd0, gnt, s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err, s_adr[15:0]};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // m0 is the reader at 0xA0, m1 the writer at 0x100 with 0xDEADBEEF.
    sys_rst_n = 1'b0;
    m0_we = 1'b0; m0_adr = 32'h0000_00A0; m0_dat_ms = 32'h1111_1111; m0_sel = 4'hF;
    m0_cti = 3'd2; m0_bte = 2'd0;
    m1_we = 1'b1; m1_adr = 32'h0000_0100; m1_dat_ms = 32'hDEAD_BEEF; m1_sel = 4'hF;
    m1_cti = 3'd0; m1_bte = 2'd0;
    s_rty = 1'b0; s_dat_sm = 32'h1234_5678;
    apply(1, 1, 1, 1, 1, 0);

    //           c0 s0 c1 s1 ak er  gnt  cyc stb we a0 a1 e0 e1 adr
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[1]  = '{0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[2]  = '{0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 1, 0, 0, 0, 0, 16'h0100};
    vecs[3]  = '{0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 1, 0, 0, 0, 0, 16'h0100};
    vecs[4]  = '{0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 1, 0, 1, 0, 0, 16'h0100};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 1, 0, 0, 0, 0, 16'h0100};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[7]  = '{1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000};
    vecs[8]  = '{1, 0, 0, 0, 1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 16'h00A0};
    vecs[9]  = '{1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 0, 1, 0, 0, 0, 16'h00A0};
    vecs[10] = '{1, 1, 0, 0, 0, 1, 2'b01, 1, 1, 0, 0, 0, 1, 0, 16'h00A0};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 16'h00A0};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 16'h0000};

    // Reset held while both masters request: nothing granted.
    @(negedge sys_clk);
    tick();
    #1;
    check("rst_gnt_cyc", {61'd0, gnt, s_cyc}, 64'd0);
    check("rst_terms", {58'd0, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, 64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    #1;
    check("rel_idle", {62'd0, gnt}, 64'd0);
    tick();
    #1;
    check("rel_gnt0", {62'd0, gnt}, 64'd1);
    check("rel_adr", {32'd0, s_adr}, 64'h0000_00A0);

    // Vector table from a fresh reset.
    @(negedge sys_clk);
    apply(0, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].ack, vecs[i].err);
      #1;
      check($sformatf("vec%0d", i), pack_out(),
            {37'd0, vecs[i].x_gnt, vecs[i].x_cyc, vecs[i].x_stb, vecs[i].x_we,
             vecs[i].x_a0, vecs[i].x_a1, vecs[i].x_e0, vecs[i].x_e1, vecs[i].x_adr});
      if (i == 4) begin
        check("m1_wdata", {32'd0, s_dat_ms}, 64'h0000_0000_DEAD_BEEF);
        check("bcast_rdata", {m0_dat_sm, m1_dat_sm}, 64'h1234_5678_1234_5678);
      end
      tick();
    end

    // Both request continuously, slave acks every cycle: 4 acks, idle, 4 acks, idle...
    apply(0, 0, 0, 0, 0, 0);
    do_reset();
    apply(1, 1, 1, 1, 1, 0);
    for (int k = 0; k < 30; k++) begin
      int ph;
      logic [1:0] eg;
      logic ea0, ea1;
      ph  = k % 10;
      eg  = (ph >= 1 && ph <= 4) ? 2'b01 : (ph >= 6) ? 2'b10 : 2'b00;
      ea0 = (ph >= 1 && ph <= 4);
      ea1 = (ph >= 6);
      #1;
      check($sformatf("rr_cyc%0d", k), {60'd0, gnt, m0_ack, m1_ack}, {60'd0, eg, ea0, ea1});
      tick();
    end

    // Long m0 burst with m1 idle: no switch; saturated counter preempts on the next ack once m1 asks.
    apply(0, 0, 0, 0, 0, 0);
    do_reset();
    apply(1, 1, 0, 0, 1, 0);
    #1;
    tick();
    begin
      int acks;
      int held;
      acks = 0;
      held = 0;
      for (int k = 0; k < 100; k++) begin
        #1;
        if (m0_ack && !m1_ack) acks++;
        if (gnt == 2'b01) held++;
        tick();
      end
      check("burst_acks", 64'(acks), 64'd100);
      check("burst_held", 64'(held), 64'd100);
    end
    apply(1, 1, 1, 1, 1, 0);
    #1;
    check("sat_last_ack", {61'd0, gnt, m0_ack}, {61'd0, 2'b01, 1'b1});
    tick();
    #1;
    check("sat_idle", {61'd0, gnt, s_cyc}, 64'd0);
    tick();
    #1;
    check("sat_gnt1", {62'd0, gnt}, 64'd2);

    // m1 takes an err on its 3rd transfer; it still counts toward the hold.
    apply(0, 0, 0, 0, 0, 0);
    do_reset();
    apply(0, 0, 1, 1, 1, 0);
    #1;
    tick();
    apply(1, 1, 1, 1, 1, 0);
    #1;
    check("err_t1", {62'd0, gnt, m1_ack}, {61'd0, 2'b10, 1'b1});
    tick();
    #1;
    check("err_t2", {62'd0, gnt, m1_ack}, {61'd0, 2'b10, 1'b1});
    tick();
    apply(1, 1, 1, 1, 0, 1);
    #1;
    check("err_t3", {59'd0, m1_err, m0_err, m1_ack, m0_ack, s_stb}, {59'd0, 5'b10001});
    tick();
    apply(1, 1, 1, 1, 1, 0);
    #1;
    check("err_t4", {61'd0, gnt, m1_ack}, {61'd0, 2'b10, 1'b1});
    tick();
    #1;
    check("err_idle", {62'd0, gnt}, 64'd0);
    tick();
    #1;
    check("err_gnt0", {62'd0, gnt}, 64'd1);

    // Reset dropped mid-burst in GNT1 takes effect without a clock edge.
    apply(0, 0, 0, 0, 0, 0);
    do_reset();
    apply(0, 0, 1, 1, 1, 0);
    tick();
    #1;
    check("mid_gnt1", {61'd0, gnt, s_cyc}, {61'd0, 2'b10, 1'b1});
    sys_rst_n = 1'b0;
    #1;
    check("mid_async", {60'd0, gnt, s_cyc, s_stb}, 64'd0);
    apply(1, 1, 1, 1, 1, 0);
    @(negedge sys_clk);
    tick();
    sys_rst_n = 1'b1;
    #1;
    check("mid_rel_idle", {62'd0, gnt}, 64'd0);
    tick();
    #1;
    check("mid_rel_gnt0", {62'd0, gnt}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wshb_rr_arbiter.md
Name: wshb_rr_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter on the sys_clk domain.
- Shares the SDRAM Wishbone slave between the VGA frame reader (master 0) and the test-pattern writer (master 1).
- Uses round-robin grant, a registered grant state machine, and a bounded-hold preemption counter, so a long VGA burst cannot starve the pattern writer and vice versa.
- Downstream side connects to the hw_support SDRAM slave.

Parameters:
- DATA_BYTES, 4, bytes per data word; data width = 8*DATA_BYTES, sel width = DATA_BYTES.
- ADDR_W, 32, address width.
- MAX_HOLD, 64, max terminated transfers per grant while the other master requests; 0 disables preemption.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle/strobe/write.
- m0_adr  in  ADDR_W  master 0 address.
- m0_dat_ms  in  8*DATA_BYTES  master 0 write data.
- m0_sel  in  DATA_BYTES  master 0 byte select.
- m0_cti  in  3; m0_bte  in  2  master 0 burst tags.
- m0_ack, m0_err, m0_rty  out  1 each  master 0 terminations.
- m0_dat_sm  out  8*DATA_BYTES  master 0 read data.
- m1_*  same set as m0_*  master 1 (pattern writer).
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADDR_W; s_dat_ms  out  8*DATA_BYTES; s_sel  out  DATA_BYTES; s_cti  out  3; s_bte  out  2  to slave.
- s_ack, s_err, s_rty  in  1 each; s_dat_sm  in  8*DATA_BYTES  from slave.
- gnt  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 = none.

Behaviour:
- States: IDLE, GNT0, GNT1; held in registers, all outputs decoded from state.
- Reset (async, sys_rst_n=0):
  - state=IDLE, last=1 (so m0 wins the first tie), hold counter=0, gnt=00.
  - s_cyc=s_stb=s_we=0, all mX_ack/err/rty=0.
  - Applies immediately even mid-transfer; downstream cycle is dropped in the same cycle.
- Request: reqX = mX_cyc.
- IDLE:
  - Only one req: go to that grant.
  - Both: grant the master that is not `last`.
  - None: stay in IDLE.
  - Transition is registered; latency is one cycle from req to s_cyc.
- GNTx:
  - Slave outputs = master x inputs, combinationally.
  - mx_ack/err/rty = s_ack/err/rty. The other master's terminations are 0.
  - Both mX_dat_sm = s_dat_sm (broadcast).
  - term = s_ack|s_err|s_rty while s_stb.
  - Hold counter increments on each term; it clears on entering any grant.
- GNTx -> IDLE, setting last=x and gnt=00, when either:
  - mx_cyc=0, or
  - preempt: MAX_HOLD>0, counter==MAX_HOLD-1, term=1 and the other master's req=1.
- Preemption happens only on a termination boundary; no transfer is ever split. The preempted master keeps stb high and simply sees no ack until it is regranted.
- Mandatory IDLE cycle between grants: s_cyc=0 for exactly one cycle on every switch. IDLE then grants the other master by round-robin.
- Preempt condition true but other req=0: no switch. Counter saturates at MAX_HOLD-1.
- Terminations in IDLE, or any term while s_stb=0, are ignored and never forwarded.
- err and rty count as terminations, the same as ack.

Test Plan:
- Reset with both cyc=1 -> gnt=00, s_cyc=0. After release: gnt=01 at cycle+1, s_adr=m0_adr.
- m1 only, single write adr=0x100, dat=0xDEADBEEF, slave ack after 2 cycles -> s_we=1, s_dat_ms=0xDEADBEEF, m1_ack pulses 1 cycle, m0_ack stays 0.
- Both request continuously, MAX_HOLD=4, slave acks every cycle -> grant sequence m0 x4 acks, 1 idle cycle, m1 x4 acks, 1 idle cycle, repeating; never 5 consecutive acks to one master.
- m0 holds 100-ack burst with m1 idle -> no switch, gnt stays 01, counter saturates, 100 acks delivered to m0.
- s_err asserted on m1's 3rd transfer -> m1_err=1 for 1 cycle, m0_err=0, counted toward hold.
- sys_rst_n low mid-burst while in GNT1 -> s_cyc/s_stb=0 the same cycle. After release, with both requesting, m0 is granted first.
